sorter_feeder: RTL and testbench

- Upstream driver for the top-5 sorter pipeline. The sorter only receives lines; this block transmits them.
- Fetches a job of signed 8-bit elements from a 256-bit-wide line SRAM, starting at a base address.
- Streams the lines into the sorter as sorter_in / sorter_en, flags the final line with last_sort and last_line_sorter_num, then waits for the sorter's final result.
- Captures the packed result and reports completion to the NPU core controller.

---
 rtl/sorter_feeder.sv | 233 +++++++++++++++++++++++
 tb/tb_sorter_feeder.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sorter_feeder.sv
// sorter_feeder: fetches a job of signed 8-bit elements from the 256-bit line
// SRAM and streams it, one line per cycle, into the top-5 sorter. It then waits
// for the sorter's final result, captures it and pulses done.
//
// Optional build macro: SORTER_FEEDER_TIMEOUT_EN
//   defined   - the result wait gives up after TIMEOUT_CYCLES cycles and
//               finishes with timeout=1, leaving result unchanged.
//   undefined - the result wait is unbounded and timeout is tied to 0.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for start; job registers hold the previous job
// CLR      | one-cycle sorter_clr pulse before the first read
// READ     | one SRAM line read per cycle, base_addr + line_cnt
// WAIT_RES | waiting for sorter_valid && last_sort_o
// FIN      | one-cycle done pulse, back to IDLE

module sorter_feeder #(
  parameter int ADDR_W         = 12,
  parameter int LEN_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  total_len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [255:0]      rd_data,
  output logic              sorter_clr,
  output logic              sorter_en,
  output logic [255:0]      sorter_in,
  output logic              last_sort,
  output logic [4:0]        last_line_sorter_num,
  input  logic              sorter_valid,
  input  logic              last_sort_o,
  input  logic [255:0]      sorter_result,
  output logic [255:0]      result,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  // Line count needs one bit more than total_len/32 so that ceil() cannot overflow.
  localparam int LINES_W = LEN_W - 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_READ,
    S_WAIT_RES,
    S_FIN
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_W-1:0]  r_base;
  logic [4:0]         r_len_lsb;
  logic [LINES_W-1:0] r_last_idx;
  logic [LINES_W-1:0] r_line_cnt;
  logic               r_rd_pend;
  logic               r_rd_last_pend;
  logic               r_sorter_en;
  logic               r_last_sort;
  logic [255:0]       r_sorter_in;
  logic [4:0]         r_last_num;
  logic [255:0]       r_result;

  logic [LINES_W-1:0] w_lines_in;
  logic               w_accept;
  logic               w_last_line;
  logic               w_final;
  logic               w_capture;
  logic               w_expire;
  logic [ADDR_W-1:0]  w_rd_addr;

  assign w_lines_in  = {1'b0, total_len[LEN_W-1:5]} + LINES_W'(|total_len[4:0]);
  assign w_accept    = (r_state == S_IDLE) && start;
  assign w_last_line = (r_line_cnt == r_last_idx);
  assign w_final     = sorter_valid && last_sort_o;
  assign w_capture   = (r_state == S_WAIT_RES) && w_final;
  assign w_rd_addr   = r_base + ADDR_W'(r_line_cnt);

`ifdef SORTER_FEEDER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] r_wait_cnt;
  logic             r_timeout;

  assign w_expire = (r_wait_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign timeout  = r_timeout;

  // Result-wait cycle counter, zero whenever the FSM is outside WAIT_RES.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_WAIT_RES) begin
      r_wait_cnt <= r_wait_cnt + TMO_W'(1);
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // Timeout flag: set on expiry unless a final result arrives that same cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_timeout <= 1'b0;
    end else if (w_accept) begin
      r_timeout <= 1'b0;
    end else if ((r_state == S_WAIT_RES) && !w_final && w_expire) begin
      r_timeout <= 1'b1;
    end
  end
`else
  logic w_unused_timeout_cfg;

  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign w_expire             = 1'b0;
  assign timeout              = 1'b0;
`endif

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a final result takes priority over timeout expiry.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (total_len == '0) ? S_FIN : S_CLR;
        end
      end
      S_CLR:  w_state_nxt = S_READ;
      S_READ: begin
        if (w_last_line) begin
          w_state_nxt = S_WAIT_RES;
        end
      end
      S_WAIT_RES: begin
        if (w_final || w_expire) begin
          w_state_nxt = S_FIN;
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Job registers latched when a start is accepted.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_base     <= '0;
      r_len_lsb  <= '0;
      r_last_idx <= '0;
    end else if (w_accept) begin
      r_base     <= base_addr;
      r_len_lsb  <= total_len[4:0];
      r_last_idx <= w_lines_in - LINES_W'(1);
    end
  end

  // Line counter: cleared in CLR, advanced once per read.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_line_cnt <= '0;
    end else if (r_state == S_CLR) begin
      r_line_cnt <= '0;
    end else if (r_state == S_READ) begin
      r_line_cnt <= r_line_cnt + LINES_W'(1);
    end
  end

  // Read pipeline: rd_data returns one cycle after rd_en and is registered
  // into sorter_in, which puts sorter_en two cycles behind its read.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rd_pend      <= 1'b0;
      r_rd_last_pend <= 1'b0;
      r_sorter_en    <= 1'b0;
      r_last_sort    <= 1'b0;
      r_sorter_in    <= '0;
    end else begin
      r_rd_pend      <= (r_state == S_READ);
      r_rd_last_pend <= (r_state == S_READ) && w_last_line;
      r_sorter_en    <= r_rd_pend;
      r_last_sort    <= r_rd_pend && r_rd_last_pend;
      if (r_rd_pend) begin
        r_sorter_in <= rd_data;
      end
    end
  end

  // Final-line element count: loaded with the final line, held until the next CLR.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_last_num <= '0;
    end else if (r_state == S_CLR) begin
      r_last_num <= '0;
    end else if (r_rd_pend && r_rd_last_pend) begin
      r_last_num <= r_len_lsb;
    end
  end

  // Result capture on the sorter's final output only.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_result <= '0;
    end else if (w_capture) begin
      r_result <= sorter_result;
    end
  end

  assign rd_en                = (r_state == S_READ);
  assign rd_addr              = rd_en ? w_rd_addr : '0;
  assign sorter_clr           = (r_state == S_CLR);
  assign sorter_en            = r_sorter_en;
  assign sorter_in            = r_sorter_in;
  assign last_sort            = r_last_sort;
  assign last_line_sorter_num = r_last_num;
  assign result               = r_result;
  assign busy                 = (r_state != S_IDLE);
  assign done                 = (r_state == S_FIN);

endmodule

// File: tb/tb_sorter_feeder.sv
// Directed bench for sorter_feeder: one task per scenario, inline checks.
// Cycle numbering: s is the CLR cycle of a job (the cycle after start is
// sampled); reads are expected at s+1.., sorter_en at s+3.., WAIT_RES from s+L+1.

module tb_sorter_feeder;

  localparam int ADDR_W = 12;
  localparam int LEN_W  = 16;
  localparam int TMO    = 16;
  localparam int LOGN   = 64;

  localparam logic [255:0] R1 = {8{32'hABCD_0123}};
  localparam logic [255:0] R2 = {8{32'h1111_2222}};
  localparam logic [255:0] RX = {8{32'hDEAD_0000}};
  localparam logic [255:0] R3 = {8{32'h3333_4444}};
  localparam logic [255:0] R4 = {8{32'h5555_6666}};
  localparam logic [255:0] R5 = {8{32'h7777_8888}};
  localparam logic [255:0] R6 = {8{32'h9999_AAAA}};
  localparam logic [255:0] R7 = {8{32'hBBBB_CCCC}};
  localparam logic [255:0] R8 = {8{32'hCAFE_F00D}};

  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  total_len = '0;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [255:0]      rd_data = '0;
  logic              sorter_clr;
  logic              sorter_en;
  logic [255:0]      sorter_in;
  logic              last_sort;
  logic [4:0]        last_line_sorter_num;
  logic              sorter_valid = 1'b0;
  logic              last_sort_o = 1'b0;
  logic [255:0]      sorter_result = '0;
  logic [255:0]      result;
  logic              busy;
  logic              done;
  logic              timeout;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  sorter_feeder #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .TIMEOUT_CYCLES(TMO)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start),
    .base_addr(base_addr), .total_len(total_len),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .sorter_clr(sorter_clr), .sorter_en(sorter_en), .sorter_in(sorter_in),
    .last_sort(last_sort), .last_line_sorter_num(last_line_sorter_num),
    .sorter_valid(sorter_valid), .last_sort_o(last_sort_o),
    .sorter_result(sorter_result), .result(result),
    .busy(busy), .done(done), .timeout(timeout)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;

  function automatic logic [255:0] pat(input logic [ADDR_W-1:0] a);
    return {8{4'h5, a, 4'hA, ~a}};
  endfunction

  // SRAM model: data valid exactly one cycle after rd_en, garbage otherwise.
  always @(posedge sys_clk) begin
    if (rd_en) rd_data <= pat(rd_addr);
    else       rd_data <= {8{32'hDEAD_BEEF}};
  end

  // Event log, sampled on the falling edge.
  int                n_rd, n_en, n_clr, n_done, n_bad;
  int                rd_cyc[LOGN];
  logic [ADDR_W-1:0] rd_log[LOGN];
  int                en_cyc[LOGN];
  logic [255:0]      en_data[LOGN];
  logic              en_last[LOGN];
  logic [4:0]        en_num[LOGN];
  int                clr_cyc[LOGN];
  int                done_cyc[LOGN];
  logic              done_tmo[LOGN];

  always @(negedge sys_clk) begin
    if (rd_en && n_rd < LOGN) begin
      rd_log[n_rd] = rd_addr; rd_cyc[n_rd] = cyc; n_rd++;
    end
    if (sorter_en && n_en < LOGN) begin
      en_data[n_en] = sorter_in; en_last[n_en] = last_sort;
      en_num[n_en] = last_line_sorter_num; en_cyc[n_en] = cyc; n_en++;
    end
    if (sorter_clr && n_clr < LOGN) begin
      clr_cyc[n_clr] = cyc; n_clr++;
    end
    if (done && n_done < LOGN) begin
      done_cyc[n_done] = cyc; done_tmo[n_done] = timeout; n_done++;
    end
    if (last_sort && !sorter_en) n_bad++;
  end

  task automatic clear_log();
    n_rd = 0; n_en = 0; n_clr = 0; n_done = 0; n_bad = 0;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge sys_clk); #1; end
  endtask

  task automatic step_to(input int c);
    int guard = 0;
    while (cyc < c && guard < 1000) begin step(1); guard++; end
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l, output int s);
    start = 1'b1; base_addr = b; total_len = l;
    step(1);
    start = 1'b0; base_addr = '0; total_len = '0;
    s = cyc;
  endtask

  task automatic pulse_start_busy(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l);
    start = 1'b1; base_addr = b; total_len = l;
    step(1);
    start = 1'b0; base_addr = '0; total_len = '0;
  endtask

  task automatic pulse_result(input logic [255:0] v, input logic last, output int c);
    sorter_valid = 1'b1; last_sort_o = last; sorter_result = v;
    c = cyc;
    step(1);
    sorter_valid = 1'b0; last_sort_o = 1'b0; sorter_result = '0;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({rd_en, rd_addr, sorter_clr, sorter_en, sorter_in, last_sort, last_line_sorter_num,
         result, busy, done, timeout} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: busy=%b rd_en=%b sorter_en=%b result=%h, want all zero",
               busy, rd_en, sorter_en, result);
    end
    step(2);
    sys_rst_n = 1'b1;
    step(3);
    tests_run++;
    if ({busy, done, rd_en, sorter_clr, sorter_en} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_idle: busy=%b done=%b rd_en=%b clr=%b en=%b, want 0", busy, done, rd_en, sorter_clr, sorter_en);
    end
  endtask

  task automatic test_single_line();
    int s, c;
    clear_log();
    do_start(12'h010, 16'd5, s);
    step(5);
    pulse_result(R1, 1'b1, c);
    step(2);
    tests_run++;
    if (n_clr !== 1 || clr_cyc[0] !== s) begin
      tests_failed++; $display("FAIL single_clr: n=%0d cyc=%0d, want n=1 cyc=%0d", n_clr, clr_cyc[0], s);
    end
    tests_run++;
    if (n_rd !== 1 || rd_log[0] !== 12'h010 || rd_cyc[0] !== s + 1) begin
      tests_failed++; $display("FAIL single_rd: n=%0d addr=%h cyc=%0d, want n=1 addr=010 cyc=%0d", n_rd, rd_log[0], rd_cyc[0], s + 1);
    end
    tests_run++;
    if (n_en !== 1 || en_cyc[0] !== s + 3 || en_last[0] !== 1'b1 || en_num[0] !== 5'd5 || en_data[0] !== pat(12'h010)) begin
      tests_failed++;
      $display("FAIL single_en: n=%0d cyc=%0d last=%b num=%0d data_ok=%b, want n=1 cyc=%0d last=1 num=5 data_ok=1",
               n_en, en_cyc[0], en_last[0], en_num[0], en_data[0] === pat(12'h010), s + 3);
    end
    tests_run++;
    if (n_done !== 1 || done_cyc[0] !== c + 1 || done_tmo[0] !== 1'b0 || result !== R1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_done: n=%0d cyc=%0d tmo=%b busy=%b result=%h, want n=1 cyc=%0d tmo=0 busy=0 result=%h",
               n_done, done_cyc[0], done_tmo[0], busy, result, c + 1, R1);
    end
    tests_run++;
    if (n_bad !== 0) begin
      tests_failed++; $display("FAIL single_last_qual: last_sort without sorter_en %0d times, want 0", n_bad);
    end
  endtask

  task automatic test_multi_line();
    int s, c;
    clear_log();
    do_start(12'h200, 16'd100, s);
    step(7);
    pulse_result(R2, 1'b1, c);
    step(2);
    tests_run++;
    if (n_rd !== 4 || n_en !== 4) begin
      tests_failed++; $display("FAIL multi_counts: reads=%0d lines=%0d, want 4 and 4", n_rd, n_en);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (rd_log[i] !== 12'(12'h200 + i) || rd_cyc[i] !== s + 1 + i) begin
        tests_failed++; $display("FAIL multi_rd%0d: addr=%h cyc=%0d, want addr=%h cyc=%0d", i, rd_log[i], rd_cyc[i], 12'(12'h200 + i), s + 1 + i);
      end
      tests_run++;
      if (en_cyc[i] !== s + 3 + i || en_last[i] !== (i == 3) || en_data[i] !== pat(12'(12'h200 + i))) begin
        tests_failed++; $display("FAIL multi_en%0d: cyc=%0d last=%b, want cyc=%0d last=%b", i, en_cyc[i], en_last[i], s + 3 + i, i == 3);
      end
    end
    tests_run++;
    if (en_num[3] !== 5'd4 || last_line_sorter_num !== 5'd4 || result !== R2 || n_done !== 1 || done_cyc[0] !== c + 1) begin
      tests_failed++;
      $display("FAIL multi_final: num=%0d held=%0d done=%0d result=%h, want num=4 held=4 done=1 result=%h",
               en_num[3], last_line_sorter_num, n_done, result, R2);
    end
  endtask

  task automatic test_exact_multiple();
    int s, c, c2;
    clear_log();
    do_start(12'h040, 16'd64, s);
    step(4);
    pulse_result(RX, 1'b0, c);
    step(3);
    tests_run++;
    if (n_done !== 0 || result !== R2 || busy !== 1'b1) begin
      tests_failed++; $display("FAIL exact_ignore: done=%0d busy=%b result=%h, want done=0 busy=1 result=%h", n_done, busy, result, R2);
    end
    pulse_result(R3, 1'b1, c2);
    step(2);
    tests_run++;
    if (n_en !== 2 || en_last[0] !== 1'b0 || en_last[1] !== 1'b1 || en_num[1] !== 5'd0) begin
      tests_failed++; $display("FAIL exact_lines: n=%0d last=%b%b num=%0d, want n=2 last=01 num=0", n_en, en_last[0], en_last[1], en_num[1]);
    end
    tests_run++;
    if (n_done !== 1 || done_cyc[0] !== c2 + 1 || result !== R3) begin
      tests_failed++; $display("FAIL exact_capture: done=%0d result=%h, want done=1 result=%h", n_done, result, R3);
    end
  endtask

  task automatic test_wrap_and_ignore();
    int s, c;
    clear_log();
    do_start(12'hFFF, 16'd40, s);
    pulse_start_busy(12'h123, 16'd5);
    step(3);
    pulse_start_busy(12'h456, 16'd7);
    pulse_result(R4, 1'b1, c);
    step(3);
    tests_run++;
    if (n_rd !== 2 || rd_log[0] !== 12'hFFF || rd_log[1] !== 12'h000) begin
      tests_failed++; $display("FAIL wrap_addr: n=%0d addr=%h,%h, want n=2 addr=fff,000", n_rd, rd_log[0], rd_log[1]);
    end
    tests_run++;
    if (n_clr !== 1 || n_en !== 2 || en_num[1] !== 5'd8 || n_done !== 1 || result !== R4) begin
      tests_failed++; $display("FAIL busy_ignore: clr=%0d lines=%0d num=%0d done=%0d result=%h, want 1 2 8 1 %h",
                               n_clr, n_en, en_num[1], n_done, result, R4);
    end
    clear_log();
    do_start(12'h555, 16'd0, s);
    step(3);
    tests_run++;
    if (n_rd !== 0 || n_clr !== 0 || n_done !== 1 || done_cyc[0] !== s || done_tmo[0] !== 1'b0) begin
      tests_failed++; $display("FAIL zero_len: reads=%0d clr=%0d done=%0d cyc=%0d tmo=%b, want 0 0 1 %0d 0",
                               n_rd, n_clr, n_done, done_cyc[0], done_tmo[0], s);
    end
    tests_run++;
    if (result !== R4 || last_line_sorter_num !== 5'd8 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL zero_len_hold: result=%h num=%0d busy=%b, want %h 8 0", result, last_line_sorter_num, busy, R4);
    end
  endtask

  task automatic test_reset_mid_job();
    int s, c;
    clear_log();
    do_start(12'h300, 16'd200, s);
    step(3);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    tests_run++;
    if ({rd_en, rd_addr, sorter_clr, sorter_en, sorter_in, last_sort, last_line_sorter_num,
         result, busy, done, timeout} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid: busy=%b rd_en=%b rd_addr=%h en=%b result=%h, want all zero", busy, rd_en, rd_addr, sorter_en, result);
    end
    step(2);
    sys_rst_n = 1'b1;
    step(1);
    clear_log();
    do_start(12'h050, 16'd33, s);
    step(6);
    pulse_result(R5, 1'b1, c);
    step(2);
    tests_run++;
    if (n_rd !== 2 || rd_log[1] !== 12'h051 || n_en !== 2 || en_num[1] !== 5'd1 || n_done !== 1 || result !== R5) begin
      tests_failed++; $display("FAIL reset_rerun: reads=%0d lines=%0d num=%0d done=%0d result=%h, want 2 2 1 1 %h",
                               n_rd, n_en, en_num[1], n_done, result, R5);
    end
  endtask

  task automatic test_back_to_back();
    int s, s2, c, c2;
    clear_log();
    do_start(12'h0A0, 16'd5, s);
    step(5);
    pulse_result(R6, 1'b1, c);
    step(1);
    do_start(12'h0B0, 16'd32, s2);
    step(5);
    pulse_result(R7, 1'b1, c2);
    step(2);
    tests_run++;
    if (n_clr !== 2 || n_done !== 2 || clr_cyc[1] !== done_cyc[0] + 2) begin
      tests_failed++; $display("FAIL b2b_timing: clr=%0d done=%0d second_clr=%0d, want 2 2 %0d", n_clr, n_done, clr_cyc[1], done_cyc[0] + 2);
    end
    tests_run++;
    if (n_en !== 2 || en_last[1] !== 1'b1 || en_num[1] !== 5'd0 || en_data[1] !== pat(12'h0B0) || result !== R7) begin
      tests_failed++; $display("FAIL b2b_second: lines=%0d last=%b num=%0d result=%h, want 2 1 0 %h", n_en, en_last[1], en_num[1], result, R7);
    end
  endtask

`ifdef SORTER_FEEDER_TIMEOUT_EN
  task automatic test_timeout();
    int s, c;
    clear_log();
    do_start(12'h060, 16'd5, s);
    step_to(s + 20);
    tests_run++;
    if (n_done !== 1 || done_cyc[0] !== s + 18 || done_tmo[0] !== 1'b1 || result !== R7 || timeout !== 1'b1) begin
      tests_failed++; $display("FAIL timeout_expire: done=%0d cyc=%0d tmo=%b result=%h, want 1 %0d 1 %h",
                               n_done, done_cyc[0], done_tmo[0], result, s + 18, R7);
    end
    clear_log();
    do_start(12'h070, 16'd5, s);
    tests_run++;
    if (timeout !== 1'b0) begin
      tests_failed++; $display("FAIL timeout_clear: timeout=%b after start, want 0", timeout);
    end
    step_to(s + 17);
    pulse_result(R8, 1'b1, c);
    step(2);
    tests_run++;
    if (n_done !== 1 || done_cyc[0] !== s + 18 || done_tmo[0] !== 1'b0 || result !== R8) begin
      tests_failed++; $display("FAIL timeout_race: done=%0d cyc=%0d tmo=%b result=%h, want 1 %0d 0 %h",
                               n_done, done_cyc[0], done_tmo[0], result, s + 18, R8);
    end
  endtask
`else
  task automatic test_no_timeout();
    int s, c;
    clear_log();
    do_start(12'h060, 16'd5, s);
    step(40);
    tests_run++;
    if (n_done !== 0 || busy !== 1'b1 || timeout !== 1'b0) begin
      tests_failed++; $display("FAIL wait_forever: done=%0d busy=%b timeout=%b, want 0 1 0", n_done, busy, timeout);
    end
    pulse_result(R8, 1'b1, c);
    step(2);
    tests_run++;
    if (n_done !== 1 || done_cyc[0] !== c + 1 || done_tmo[0] !== 1'b0 || result !== R8) begin
      tests_failed++; $display("FAIL late_result: done=%0d tmo=%b result=%h, want 1 0 %h", n_done, done_tmo[0], result, R8);
    end
  endtask
`endif

  initial begin
    clear_log();
    step(1);
    test_reset();
    test_single_line();
    test_multi_line();
    test_exact_multiple();
    test_wrap_and_ignore();
    test_reset_mid_job();
    test_back_to_back();
`ifdef SORTER_FEEDER_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
